fp16_accum_seq: RTL and testbench
=================================

Name: fp16_accum_seq

Overview:
- Sequencer that reduces a stream of fp16 operands to a single sum, using one external fpadder instance (16-bit half-precision, registered output).
- Owns the adder's operand inputs and observes its registered sum. It tracks the adder's pipeline latency so each add completes before the next is issued.
- Sits between an operand source (valid/ready) and a result consumer (valid/ready) in the float MAC datapath.

Parameters:
- LEN_W, 8: width of the vector-length field; max vector length 2^LEN_W-1.
- ADD_LAT, 1: number of register stages inside the adder between operand inputs and sum output (fpadder = 1).

Ports:
- CLK, input, 1: clock, rising edge.
- RESET, input, 1: synchronous, active-high reset.
- start, input, 1: begin a reduction; sampled only in IDLE.
- len, input, LEN_W: number of operands; sampled with start.
- in_data, input, 16: fp16 operand.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: block accepts in_data this cycle.
- add_a, output, 16: adder operand A (running accumulator); registered.
- add_b, output, 16: adder operand B (new element); registered.
- add_sum, input, 16: adder registered sum.
- res_data, output, 16: reduction result.
- res_valid, output, 1: result valid.
- res_ready, input, 1: consumer accepts result.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset, synchronous, takes priority over everything including mid-operation:
  - state=IDLE.
  - in_ready=0, res_valid=0, busy=0.
  - add_a=add_b=res_data=0x0000.
  - internal acc=0, remaining count=0, wait counter=0.
  - Any in-flight adder result is discarded.
- States: IDLE, FIRST, FETCH, WAIT, DONE.
- IDLE:
  - start=1 and len=0: res_data<=0x0000, go DONE.
  - start=1 and len>=1: remaining<=len, go FIRST.
  - start in any other state is ignored.
- FIRST: in_ready=1. On in_valid&in_ready: acc<=in_data, remaining<=remaining-1. Go DONE if remaining was 1, else FETCH. No adder issue.
- FETCH: in_ready=1. On handshake: add_a<=acc, add_b<=in_data, wait counter<=ADD_LAT, go WAIT. Without in_valid, stay in FETCH; add_a/add_b hold.
- WAIT:
  - in_ready=0; add_a/add_b held stable.
  - Counter decrements each cycle while nonzero.
  - At the edge where counter==0: acc<=add_sum, remaining<=remaining-1. Go DONE (res_data<=add_sum) if remaining was 1, else FETCH.
  - WAIT therefore lasts exactly ADD_LAT+1 cycles.
- DONE:
  - res_valid=1; res_data stable until handshake.
  - On res_valid&res_ready: go IDLE.
  - A start in the cycle after the handshake (IDLE) is accepted.
- Latency for len=N>=2 with no stalls: (N-1)*(ADD_LAT+2)+1 cycles from first accept to res_valid.
- The block does no arithmetic; zero/inf/NaN propagation follows the adder's special-value rules.
- in_ready is a pure function of state (no combinational path from in_valid).
- res_valid is a pure function of state (no combinational path from res_ready).
- len is captured at start; later changes to len have no effect.
- remaining counts down; no wrap: it is never decremented at 0.

Optional Feature:
- Macro: FP16_ACC_NAN_SKIP_EN.
- Defined:
  - NaN detect on any accepted operand: exp==5'h1F && mant!=0.
  - Detection sets a sticky flag; acc<=0x7C01.
  - While sticky, FETCH accepts one element per cycle with no adder issue and no WAIT.
  - Final res_data=0x7C01. Flag clears on DONE exit and on RESET.
- Undefined: NaN operands go through the adder like any other value; timing is unchanged.

Test Plan:
- len=3, in 0x3C00,0x3C00,0x4000, res_ready=1 -> res_data=0x4400. res_valid rises 7 cycles after first accept (ADD_LAT=1).
- len=0 start -> res_valid next cycle, res_data=0x0000, no in_ready pulse. len=1, in 0xC500 -> res_data=0xC500, add_a/add_b never change.
- len=4 with in_valid low 3 cycles in FETCH, and res_ready held low 5 cycles in DONE -> add_a/add_b stable during stalls; res_data stable; exactly 4 input handshakes; one result handshake.
- Assert RESET during WAIT of a len=5 run -> next cycle IDLE, busy=0, in_ready=0, add_a=add_b=0. A new len=2 run, 0x3C00+0x3C00, yields 0x4000.
- start pulsed while busy -> ignored; len changed after start -> ignored; result matches original len.
- FP16_ACC_NAN_SKIP_EN defined: len=4, in 0x3C00,0x7E00,0x3C00,0x3C00 -> res_data=0x7C01. Last two elements accepted on consecutive cycles with no WAIT. Macro undefined: same stimulus -> 0x7C01 with normal WAIT timing.

Source files
------------

// File: rtl/fp16_accum_seq.sv
// fp16_accum_seq: sequences one external registered fp16 adder to reduce an operand stream to a sum.
// Optional NaN short-circuit enabled by defining FP16_ACC_NAN_SKIP_EN.
module fp16_accum_seq #(
  parameter int LEN_W   = 8,
  parameter int ADD_LAT = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  output logic [15:0]      res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam int CNT_W = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ADD_LAT);
  localparam logic [15:0] NAN_CANON = 16'h7C01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_FETCH,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      add_a_q, add_a_d;
  logic [15:0]      add_b_q, add_b_d;
  logic [15:0]      res_q, res_d;
  logic             nan_q, nan_d;

  logic accept;
  logic last;
  logic in_nan;
  logic skip;

`ifdef FP16_ACC_NAN_SKIP_EN
  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
  endfunction

  assign in_nan = is_nan(in_data);
`else
  assign in_nan = 1'b0;
`endif

  // Handshake flags depend on state only, never on the partner's valid/ready.
  assign in_ready  = (state_q == S_FIRST) || (state_q == S_FETCH);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign res_data  = res_q;

  assign accept = in_valid && in_ready;
  assign last   = (rem_q == LEN_W'(1));
  assign skip   = nan_q || in_nan;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    res_d   = res_q;
    nan_d   = nan_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            res_d   = 16'h0000;
            state_d = S_DONE;
          end else begin
            rem_d   = len;
            state_d = S_FIRST;
          end
        end
      end

      S_FIRST: begin
        if (accept) begin
          acc_d = in_nan ? NAN_CANON : in_data;
          nan_d = nan_q || in_nan;
          if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
          if (last) begin
            res_d   = in_nan ? NAN_CANON : in_data;
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        if (accept) begin
          if (skip) begin
            // Sum is already NaN: consume the element without touching the adder.
            nan_d = 1'b1;
            acc_d = NAN_CANON;
            if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
            if (last) begin
              res_d   = NAN_CANON;
              state_d = S_DONE;
            end
          end else begin
            add_a_d = acc_q;
            add_b_d = in_data;
            cnt_d   = LAT_INIT;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          acc_d = add_sum;
          if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
          if (last) begin
            res_d   = add_sum;
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_DONE: begin
        if (res_ready) begin
          nan_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      acc_q   <= 16'h0000;
      rem_q   <= '0;
      cnt_q   <= '0;
      add_a_q <= 16'h0000;
      add_b_q <= 16'h0000;
      res_q   <= 16'h0000;
      nan_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      res_q   <= res_d;
      nan_q   <= nan_d;
    end
  end

endmodule

// File: tb/tb_fp16_accum_seq.sv
// Scoreboard bench for fp16_accum_seq with a registered fp16 adder model covering the directed vectors.
module tb_fp16_accum_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [7:0]  len;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int in_hs    = 0;
  int res_hs   = 0;
  int rdy_cnt  = 0;
  int rv_cyc   = 0;
  logic rv_prev = 1'b0;
  logic [15:0] sb[$];
  int acc_cyc[$];

  fp16_accum_seq #(.LEN_W(8), .ADD_LAT(1)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  function automatic logic is_nan16(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
  endfunction

  // Hand-computed sums for the operand pairs the vectors produce; NaN inputs give canonical 0x7C01.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    if (is_nan16(a) || is_nan16(b)) return 16'h7C01;
    case ({a, b})
      {16'h3C00, 16'h3C00}: return 16'h4000;
      {16'h4000, 16'h3C00}: return 16'h4200;
      {16'h4200, 16'h3C00}: return 16'h4400;
      {16'h4000, 16'h4000}: return 16'h4400;
      default:              return 16'h1234;
    endcase
  endfunction

  initial add_sum = 16'h0000;
  always @(posedge CLK) add_sum <= fp_add(add_a, add_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      if (in_valid && in_ready) begin
        in_hs++;
        acc_cyc.push_back(cyc);
      end
      if (in_ready) rdy_cnt++;
      if (res_valid && !rv_prev) rv_cyc = cyc;
      rv_prev = res_valid;
      if (res_valid && res_ready) begin
        res_hs++;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: got result %0h expected none", res_data);
        end else begin
          check("result", res_data, sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_run(input logic [7:0] l, input logic [15:0] exp);
    tick();
    start = 1'b1;
    len   = l;
    sb.push_back(exp);
    acc_cyc.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("send_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_res();
    int base = res_hs;
    int n = 0;
    while (res_hs == base && n < 200) begin
      tick();
      n++;
    end
    check("res_timeout", res_hs != base, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, rs0, rdy0;
    logic ok;
    logic [15:0] a0, b0;

    RESET = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; res_ready = 1'b1;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_add_a", add_a, 16'h0000);
    check("rst_add_b", add_b, 16'h0000);
    check("rst_res_data", res_data, 16'h0000);
    RESET = 1'b0;

    // 1 + 1 + 2 = 4, first accept to res_valid = 7 cycles
    start_run(8'd3, 16'h4400);
    send(16'h3C00); send(16'h3C00); send(16'h4000);
    wait_res();
    check("lat_len3", rv_cyc - acc_cyc[0], 7);

    // len=0: immediate result, no in_ready
    rdy0 = rdy_cnt;
    start_run(8'd0, 16'h0000);
    check("len0_valid", res_valid, 1'b1);
    wait_res();
    check("len0_no_ready", rdy_cnt - rdy0, 0);

    // len=1: pass-through, adder operands untouched
    a0 = add_a; b0 = add_b;
    start_run(8'd1, 16'hC500);
    send(16'hC500);
    wait_res();
    check("len1_add_a", add_a, a0);
    check("len1_add_b", add_b, b0);

    // len=4 with input stall in FETCH and output stall in DONE
    hs0 = in_hs; rs0 = res_hs;
    start_run(8'd4, 16'h4400);
    send(16'h3C00); send(16'h3C00);
    begin
      int n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
    end
    ok = 1'b1;
    repeat (3) begin
      tick();
      ok &= (in_ready && add_a == 16'h3C00 && add_b == 16'h3C00);
    end
    check("fetch_stall_hold", ok, 1'b1);
    send(16'h3C00);
    res_ready = 1'b0;
    send(16'h3C00);
    begin
      int n = 0;
      while (!res_valid && n < 20) begin tick(); n++; end
    end
    ok = 1'b1;
    repeat (5) begin
      tick();
      ok &= (res_valid && res_data == 16'h4400 && add_a == 16'h4200 && add_b == 16'h3C00);
    end
    check("done_stall_hold", ok, 1'b1);
    res_ready = 1'b1;
    wait_res();
    check("stall_in_hs", in_hs - hs0, 4);
    check("stall_res_hs", res_hs - rs0, 1);

    // reset during WAIT of a len=5 run
    start_run(8'd5, 16'h4400);
    send(16'h3C00); send(16'h3C00);
    RESET = 1'b1;
    sb.delete();
    tick();
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_add_a", add_a, 16'h0000);
    check("midrst_add_b", add_b, 16'h0000);
    RESET = 1'b0;
    start_run(8'd2, 16'h4000);
    send(16'h3C00); send(16'h3C00);
    wait_res();

    // start and len changes while busy are ignored
    hs0 = in_hs;
    start_run(8'd3, 16'h4200);
    send(16'h3C00);
    start = 1'b1;
    len   = 8'd1;
    send(16'h3C00);
    start = 1'b0;
    send(16'h3C00);
    wait_res();
    check("busy_start_in_hs", in_hs - hs0, 3);
    check("busy_start_idle", busy, 1'b0);

    // NaN operand: result canonical NaN; gap between last two accepts depends on the build
    start_run(8'd4, 16'h7C01);
    send(16'h3C00); send(16'h7E00); send(16'h3C00); send(16'h3C00);
    wait_res();
`ifdef FP16_ACC_NAN_SKIP_EN
    check("nan_gap", acc_cyc[3] - acc_cyc[2], 1);
`else
    check("nan_gap", acc_cyc[3] - acc_cyc[2], 3);
`endif

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
